// File: rtl/controle_vedacao_multi.sv
// controle_vedacao_multi: sealing-station controller firing N stopper heads, simultaneous or sequential
module controle_vedacao_multi #(
  parameter int N_CABECAS       = 4,
  parameter int W_TEMPO         = 26,
  parameter int TEMPO_VEDACAO   = 25000000,
  parameter int TEMPO_INTERVALO = 0,
  parameter int MODO_SEQ        = 0,
  localparam int QW             = $clog2(N_CABECAS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_iniciar,
  input  logic [N_CABECAS-1:0] mascara,
  input  logic                 alarme_rolha,
  output logic [N_CABECAS-1:0] vedacao_ativa,
  output logic                 decrementar_rolha,
  output logic [QW-1:0]        qtd_rolha,
  output logic                 tarefa_concluida,
  output logic                 erro_vedacao
);
  typedef enum logic [2:0] {IDLE, VEDANDO, INTERVALO, CONCLUIDO, ABORTADO} state_t;
  localparam logic [W_TEMPO-1:0] FIM_V = W_TEMPO'(TEMPO_VEDACAO - 1);
  localparam logic [W_TEMPO-1:0] FIM_I = W_TEMPO'(TEMPO_INTERVALO > 0 ? TEMPO_INTERVALO - 1 : 0);
  state_t               state;
  logic [W_TEMPO-1:0]   timer;
  logic [N_CABECAS-1:0] mask_q, cur, rem;
  function automatic logic [N_CABECAS-1:0] lowbit(input logic [N_CABECAS-1:0] m);
    return m & (~m + N_CABECAS'(1));
  endfunction
  function automatic logic [QW-1:0] popcount(input logic [N_CABECAS-1:0] m);
    logic [QW-1:0] c;
    c = '0;
    for (int i = 0; i < N_CABECAS; i++) c = c + QW'(m[i]);
    return c;
  endfunction
  // heads being driven now and what remains once they finish
  always_comb begin
    cur = (MODO_SEQ != 0) ? lowbit(mask_q) : mask_q;
    rem = mask_q & ~cur;
  end
  // sealing sequencer with registered Moore outputs computed alongside each transition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      timer             <= '0;
      mask_q            <= '0;
      vedacao_ativa     <= '0;
      decrementar_rolha <= 1'b0;
      qtd_rolha         <= '0;
      tarefa_concluida  <= 1'b0;
      erro_vedacao      <= 1'b0;
    end else begin
      decrementar_rolha <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (cmd_iniciar && !alarme_rolha) begin
            if (mascara != '0) begin
              state             <= VEDANDO;
              mask_q            <= mascara;
              vedacao_ativa     <= (MODO_SEQ != 0) ? lowbit(mascara) : mascara;
              decrementar_rolha <= 1'b1;
              qtd_rolha         <= (MODO_SEQ != 0) ? QW'(1) : popcount(mascara);
            end else begin
              state            <= CONCLUIDO;
              tarefa_concluida <= 1'b1;
            end
          end
        end
        VEDANDO: begin
          if (alarme_rolha) begin
            state         <= ABORTADO;
            vedacao_ativa <= '0;
            erro_vedacao  <= 1'b1;
          end else if (timer == FIM_V) begin
            timer  <= '0;
            mask_q <= rem;
            if (rem == '0 || MODO_SEQ == 0) begin
              state            <= CONCLUIDO;
              vedacao_ativa    <= '0;
              tarefa_concluida <= 1'b1;
            end else if (TEMPO_INTERVALO > 0) begin
              state         <= INTERVALO;
              vedacao_ativa <= '0;
            end else begin
              vedacao_ativa     <= lowbit(rem);
              decrementar_rolha <= 1'b1;
              qtd_rolha         <= QW'(1);
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        INTERVALO: begin
          if (alarme_rolha) begin
            state        <= ABORTADO;
            erro_vedacao <= 1'b1;
          end else if (timer == FIM_I) begin
            state             <= VEDANDO;
            timer             <= '0;
            vedacao_ativa     <= cur;
            decrementar_rolha <= 1'b1;
            qtd_rolha         <= QW'(1);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CONCLUIDO, ABORTADO: begin
          if (!cmd_iniciar) begin
            state            <= IDLE;
            mask_q           <= '0;
            tarefa_concluida <= 1'b0;
            erro_vedacao     <= 1'b0;
          end
        end
        default: begin
          state             <= IDLE;
          timer             <= '0;
          mask_q            <= '0;
          vedacao_ativa     <= '0;
          qtd_rolha         <= '0;
          tarefa_concluida  <= 1'b0;
          erro_vedacao      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_controle_vedacao_multi.sv
// tb_controle_vedacao_multi: directed checks of simultaneous and sequential sealing controllers
module tb_controle_vedacao_multi;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic cmd_a = 1'b0, alarm_a = 1'b0, cmd_b = 1'b0, alarm_b = 1'b0;
  logic [3:0] mask_a = '0, mask_b = '0, ved_a, ved_b;
  logic dec_a, dec_b, tar_a, tar_b, err_a, err_b;
  logic [2:0] qtd_a, qtd_b;
  int n = 0, errs = 0, pulses_b = 0, base;
  controle_vedacao_multi #(.N_CABECAS(4), .TEMPO_VEDACAO(4), .TEMPO_INTERVALO(0), .MODO_SEQ(0)) dut_a (
    .clk(clk), .reset(reset), .cmd_iniciar(cmd_a), .mascara(mask_a), .alarme_rolha(alarm_a),
    .vedacao_ativa(ved_a), .decrementar_rolha(dec_a), .qtd_rolha(qtd_a),
    .tarefa_concluida(tar_a), .erro_vedacao(err_a));
  controle_vedacao_multi #(.N_CABECAS(4), .TEMPO_VEDACAO(4), .TEMPO_INTERVALO(2), .MODO_SEQ(1)) dut_b (
    .clk(clk), .reset(reset), .cmd_iniciar(cmd_b), .mascara(mask_b), .alarme_rolha(alarm_b),
    .vedacao_ativa(ved_b), .decrementar_rolha(dec_b), .qtd_rolha(qtd_b),
    .tarefa_concluida(tar_b), .erro_vedacao(err_b));
  always @(negedge clk) if (dec_b) pulses_b <= pulses_b + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ca(input string tag, input logic [3:0] v, input logic d, input logic [2:0] q, input logic t, input logic e);
    chk(tag, {ved_a, dec_a, dec_a ? qtd_a : 3'd0, tar_a, err_a}, {v, d, d ? q : 3'd0, t, e});
  endtask
  task automatic cb(input string tag, input logic [3:0] v, input logic d, input logic [2:0] q, input logic t, input logic e);
    chk(tag, {ved_b, dec_b, dec_b ? qtd_b : 3'd0, tar_b, err_b}, {v, d, d ? q : 3'd0, t, e});
  endtask
  initial begin
    #12;
    ca("reset_a", 4'b0000, 0, 0, 0, 0);
    cb("reset_b", 4'b0000, 0, 0, 0, 0);
    reset = 1'b1;
    cmd_a = 1'b1; mask_a = 4'b1011;
    tick; ca("mid_k1", 4'b1011, 1, 3, 0, 0);
    tick; ca("mid_k2", 4'b1011, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1 ca("async_rst", 4'b0000, 0, 0, 0, 0);
    #1 reset = 1'b1;
    tick; ca("sim_k1", 4'b1011, 1, 3, 0, 0);
    mask_a = 4'b0001;
    for (int i = 2; i <= 4; i++) begin
      tick; ca($sformatf("sim_k%0d", i), 4'b1011, 0, 0, 0, 0);
    end
    tick; ca("sim_done", 4'b0000, 0, 0, 1, 0);
    tick; ca("sim_hold", 4'b0000, 0, 0, 1, 0);
    cmd_a = 1'b0;
    tick; ca("sim_idle", 4'b0000, 0, 0, 0, 0);
    cmd_a = 1'b1; mask_a = 4'b0000;
    tick; ca("zero_mask", 4'b0000, 0, 0, 1, 0);
    cmd_a = 1'b0;
    tick; ca("zero_idle", 4'b0000, 0, 0, 0, 0);
    cmd_a = 1'b1; mask_a = 4'b1011; alarm_a = 1'b1;
    tick; tick; ca("alarm_start", 4'b0000, 0, 0, 0, 0);
    alarm_a = 1'b0;
    tick; ca("col_k1", 4'b1011, 1, 3, 0, 0);
    tick; tick; tick; ca("col_k4", 4'b1011, 0, 0, 0, 0);
    alarm_a = 1'b1;
    tick; ca("col_abort", 4'b0000, 0, 0, 0, 1);
    alarm_a = 1'b0; cmd_a = 1'b0;
    tick; ca("col_idle", 4'b0000, 0, 0, 0, 0);
    base = pulses_b;
    cmd_b = 1'b1; mask_b = 4'b1010;
    tick; cb("seq_h1_k1", 4'b0010, 1, 1, 0, 0);
    mask_b = 4'b1111;
    for (int i = 2; i <= 4; i++) begin
      tick; cb($sformatf("seq_h1_k%0d", i), 4'b0010, 0, 0, 0, 0);
    end
    tick; cb("seq_gap1", 4'b0000, 0, 0, 0, 0);
    tick; cb("seq_gap2", 4'b0000, 0, 0, 0, 0);
    tick; cb("seq_h3_k7", 4'b1000, 1, 1, 0, 0);
    for (int i = 8; i <= 10; i++) begin
      tick; cb($sformatf("seq_h3_k%0d", i), 4'b1000, 0, 0, 0, 0);
    end
    tick; cb("seq_done_k11", 4'b0000, 0, 0, 1, 0);
    chk("seq_pulses", pulses_b - base, 2);
    cmd_b = 1'b0;
    tick; cb("seq_idle", 4'b0000, 0, 0, 0, 0);
    base = pulses_b;
    cmd_b = 1'b1; mask_b = 4'b1010;
    repeat (7) tick;
    cb("ab_h3", 4'b1000, 1, 1, 0, 0);
    tick;
    alarm_b = 1'b1;
    tick; cb("ab_abort", 4'b0000, 0, 0, 0, 1);
    tick; cb("ab_hold", 4'b0000, 0, 0, 0, 1);
    chk("ab_pulses", pulses_b - base, 2);
    alarm_b = 1'b0; cmd_b = 1'b0;
    tick; cb("ab_idle", 4'b0000, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule
